// File: rtl/snake_move_scheduler.sv
// rtl/snake_move_scheduler.sv - snake head motion sequencer with 2-entry turn queue
module snake_move_scheduler #(
  parameter int TICK_DIV = 25000000,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int X_START  = 80,
  parameter int Y_START  = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic       DIR_REQ_VALID,
  input  logic [1:0] DIR_REQ,
  output logic [1:0] NAV_STATE,
  output logic [7:0] HEAD_X,
  output logic [6:0] HEAD_Y,
  output logic       MOVE,
  output logic [1:0] Q_COUNT,
  output logic       DROP
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  logic [CW-1:0] tick_cnt;
  logic [1:0]    q0, q1;  // q0 oldest, q1 newest when two entries are held
  logic          tick, pop, push, turn_ok, drop_now;
  logic [1:0]    ref_dir, next_dir;
  logic [7:0]    next_x;
  logic [6:0]    next_y;

  always_comb begin
    tick     = RUN && (tick_cnt == TICK_LAST);
    pop      = tick && (Q_COUNT != 2'd0);
    ref_dir  = (Q_COUNT == 2'd2) ? q1 : (Q_COUNT == 2'd1) ? q0 : NAV_STATE;
    // 3-d on a 2-bit code is its bitwise inverse
    turn_ok  = DIR_REQ_VALID && (DIR_REQ != ref_dir) && (DIR_REQ != ~ref_dir);
    push     = turn_ok && ((Q_COUNT != 2'd2) || pop);
    drop_now = turn_ok && (Q_COUNT == 2'd2) && !pop;
    next_dir = pop ? q0 : NAV_STATE;

    next_x = HEAD_X;
    next_y = HEAD_Y;
    case (next_dir)
      DIR_UP:    next_y = (HEAD_Y == 7'd0) ? 7'(Y_MAX) : HEAD_Y - 7'd1;
      DIR_DOWN:  next_y = (HEAD_Y == 7'(Y_MAX)) ? 7'd0 : HEAD_Y + 7'd1;
      DIR_LEFT:  next_x = (HEAD_X == 8'd0) ? 8'(X_MAX) : HEAD_X - 8'd1;
      DIR_RIGHT: next_x = (HEAD_X == 8'(X_MAX)) ? 8'd0 : HEAD_X + 8'd1;
      default:   next_x = HEAD_X;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tick_cnt  <= '0;
      NAV_STATE <= DIR_UP;
      HEAD_X    <= 8'(X_START);
      HEAD_Y    <= 7'(Y_START);
      MOVE      <= 1'b0;
      DROP      <= 1'b0;
      Q_COUNT   <= 2'd0;
      q0        <= 2'd0;
      q1        <= 2'd0;
    end else begin
      if (RUN) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (tick) begin
        NAV_STATE <= next_dir;
        HEAD_X    <= next_x;
        HEAD_Y    <= next_y;
      end
      MOVE <= tick;
      DROP <= drop_now;

      // Pop shifts q1 down before a same-cycle push lands behind it
      if (pop) begin
        if (Q_COUNT == 2'd2) begin
          q0 <= q1;
          if (push) q1 <= DIR_REQ;
        end else if (push) begin
          q0 <= DIR_REQ;
        end
      end else if (push) begin
        if (Q_COUNT == 2'd0) q0 <= DIR_REQ;
        else q1 <= DIR_REQ;
      end
      Q_COUNT <= Q_COUNT + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_snake_move_scheduler.sv
// tb/tb_snake_move_scheduler.sv - vector table plus scoreboard bench for snake_move_scheduler
module tb_snake_move_scheduler;

  logic       CLK = 1'b0;
  logic       RESET, RUN, DIR_REQ_VALID;
  logic [1:0] DIR_REQ, NAV_STATE, Q_COUNT;
  logic [7:0] HEAD_X;
  logic [6:0] HEAD_Y;
  logic       MOVE, DROP;

  snake_move_scheduler #(.TICK_DIV(4), .X_MAX(159), .Y_MAX(119), .X_START(80), .Y_START(60)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .DIR_REQ_VALID(DIR_REQ_VALID), .DIR_REQ(DIR_REQ),
    .NAV_STATE(NAV_STATE), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .MOVE(MOVE),
    .Q_COUNT(Q_COUNT), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       run, valid;
    logic [1:0] req;
    logic [1:0] nav;
    logic [7:0] x;
    logic [6:0] y;
    logic       mv;
    logic [1:0] q;
    logic       dr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic v, input logic [1:0] d, input logic [1:0] nav,
                     input logic [7:0] x, input logic [6:0] y, input logic mv,
                     input logic [1:0] q, input logic dr);
    vec_t t;
    t.run = r; t.valid = v; t.req = d; t.nav = nav; t.x = x; t.y = y;
    t.mv = mv; t.q = q; t.dr = dr;
    vecs.push_back(t);
  endtask

  task automatic compare(input string name, input vec_t e);
    checks++;
    if ({NAV_STATE, HEAD_X, HEAD_Y, MOVE, Q_COUNT, DROP} !== {e.nav, e.x, e.y, e.mv, e.q, e.dr}) begin
      errors++;
      $display("FAIL %s: got nav=%0d x=%0d y=%0d move=%0d q=%0d drop=%0d, expected nav=%0d x=%0d y=%0d move=%0d q=%0d drop=%0d",
               name, NAV_STATE, HEAD_X, HEAD_Y, MOVE, Q_COUNT, DROP,
               e.nav, e.x, e.y, e.mv, e.q, e.dr);
    end
  endtask

  // Called at posedge+1: drive, queue expectation, step one edge, pop and compare
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    RUN = v.run; DIR_REQ_VALID = v.valid; DIR_REQ = v.req;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    compare(name, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    vec_t rst_v, t;
    logic [7:0] ex;
    RESET = 1'b1; RUN = 1'b1; DIR_REQ_VALID = 1'b0; DIR_REQ = 2'd0;
    rst_v.run = 1'b0; rst_v.valid = 1'b0; rst_v.req = 2'd0; rst_v.nav = 2'd0;
    rst_v.x = 8'd80; rst_v.y = 7'd60; rst_v.mv = 1'b0; rst_v.q = 2'd0; rst_v.dr = 1'b0;

    // Straight motion upward
    repeat (3) add(1, 0, 0, 0, 80, 60, 0, 0, 0);
    add(1, 0, 0, 0, 80, 59, 1, 0, 0);
    repeat (3) add(1, 0, 0, 0, 80, 59, 0, 0, 0);
    add(1, 0, 0, 0, 80, 58, 1, 0, 0);
    // Reversal and duplicate filtered
    add(1, 1, 3, 0, 80, 58, 0, 0, 0);
    add(1, 1, 0, 0, 80, 58, 0, 0, 0);
    add(1, 0, 0, 0, 80, 58, 0, 0, 0);
    add(1, 0, 0, 0, 80, 57, 1, 0, 0);
    // Double turn LEFT then DOWN, one per tick
    add(1, 1, 1, 0, 80, 57, 0, 1, 0);
    add(1, 1, 3, 0, 80, 57, 0, 2, 0);
    add(1, 0, 0, 0, 80, 57, 0, 2, 0);
    add(1, 0, 0, 1, 79, 57, 1, 1, 0);
    repeat (3) add(1, 0, 0, 1, 79, 57, 0, 1, 0);
    add(1, 0, 0, 3, 79, 58, 1, 0, 0);
    // Paused: queue LEFT, UP, then RIGHT overflows; reversal on full queue is silent
    add(0, 1, 1, 3, 79, 58, 0, 1, 0);
    add(0, 1, 0, 3, 79, 58, 0, 2, 0);
    add(0, 1, 2, 3, 79, 58, 0, 2, 1);
    add(0, 1, 3, 3, 79, 58, 0, 2, 0);
    add(0, 0, 0, 3, 79, 58, 0, 2, 0);
    // Push during pop on a full queue
    repeat (3) add(1, 0, 0, 3, 79, 58, 0, 2, 0);
    add(1, 1, 2, 1, 78, 58, 1, 2, 0);
    repeat (3) add(1, 0, 0, 1, 78, 58, 0, 2, 0);
    add(1, 0, 0, 0, 78, 57, 1, 1, 0);
    repeat (3) add(1, 0, 0, 0, 78, 57, 0, 1, 0);
    add(1, 0, 0, 2, 79, 57, 1, 0, 0);
    // Request in the tick cycle waits a tick; push+pop at count 1
    repeat (3) add(1, 0, 0, 2, 79, 57, 0, 0, 0);
    add(1, 1, 0, 2, 80, 57, 1, 1, 0);
    repeat (3) add(1, 0, 0, 2, 80, 57, 0, 1, 0);
    add(1, 1, 1, 0, 80, 56, 1, 1, 0);
    repeat (3) add(1, 0, 0, 0, 80, 56, 0, 1, 0);
    add(1, 0, 0, 1, 79, 56, 1, 0, 0);

    repeat (3) @(posedge CLK);
    #1;
    compare("reset_hold", rst_v);
    RESET = 1'b0;

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Travel LEFT across X=0 to X_MAX
    ex = 8'd79;
    for (int k = 0; k < 80; k++) begin
      for (int c = 0; c < 4; c++) begin
        t = rst_v; t.run = 1'b1; t.nav = 2'd1; t.y = 7'd56;
        if (c == 3) begin
          ex = (ex == 8'd0) ? 8'd159 : ex - 8'd1;
          t.mv = 1'b1;
        end
        t.x = ex;
        apply($sformatf("wrap_t%0d_c%0d", k, c), t);
      end
    end

    // Queue a turn, then reset mid-count
    t = rst_v; t.run = 1'b1; t.valid = 1'b1; t.req = 2'd0;
    t.nav = 2'd1; t.x = 8'd159; t.y = 7'd56; t.q = 2'd1;
    apply("pre_reset_push", t);
    t.valid = 1'b0;
    apply("pre_reset_idle", t);
    RESET = 1'b1;
    #1;
    compare("reset_async", rst_v);
    @(posedge CLK);
    #1;
    compare("reset_held_edge", rst_v);
    RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      t = rst_v; t.run = 1'b1;
      if (c == 3) begin t.mv = 1'b1; t.y = 7'd59; end
      apply($sformatf("post_reset_c%0d", c), t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
